// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory read at a time. The address to
// fetch always comes from the branch facility (i_next_instr_addr), latched once
// after reset and again in each cycle an instruction is handed to the identify
// stage. Any protocol or alignment problem parks the unit in a terminal error
// state until reset.
// Vectors use big-endian bit numbering: bit 0 is the MSB.
module instr_fetch #(
    parameter logic [0:63] RESET_ADDR = 64'h0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [0:63] i_next_instr_addr,
    output logic        o_stall,
    output logic        o_mem_req_valid,
    input  logic        i_mem_req_ready,
    output logic [0:63] o_mem_addr,
    input  logic        i_mem_rsp_valid,
    input  logic [0:31] i_mem_rsp_data,
    input  logic        i_mem_rsp_err,
    output logic [0:31] o_instr,
    output logic [0:63] o_instr_addr,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_fetch_count,
    output logic        o_err,
    output logic [1:0]  o_err_code
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StOut,
        StErr
    } state_e;

    localparam logic [1:0] ErrNone       = 2'b00;
    localparam logic [1:0] ErrMisaligned = 2'b01;
    localparam logic [1:0] ErrBus        = 2'b10;
    localparam logic [1:0] ErrUnexpected = 2'b11;

    state_e      state_q, state_d;
    logic [0:63] addr_q, addr_d;
    logic [0:31] instr_q, instr_d;
    logic [31:0] count_q, count_d;
    logic [1:0]  err_code_q, err_code_d;

    logic misaligned;
    logic handshake;

    // Word alignment: the two LSBs (bits 62 and 63 in this numbering) must be 0.
    assign misaligned = (addr_q[62:63] != 2'b00);

    // A response arriving in OUT is an error and takes priority over delivery.
    assign handshake = (state_q == StOut) && i_instr_ready && !i_mem_rsp_valid;

    // State and datapath registers, asynchronously reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StIdle;
            addr_q     <= RESET_ADDR;
            instr_q    <= '0;
            count_q    <= '0;
            err_code_q <= ErrNone;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            count_q    <= count_d;
            err_code_q <= err_code_d;
        end
    end

    // Next-state and datapath update rules.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        count_d    = count_q;
        err_code_d = err_code_q;
        unique case (state_q)
            StIdle: begin
                if (i_mem_rsp_valid) begin
                    state_d    = StErr;
                    err_code_d = ErrUnexpected;
                end else begin
                    addr_d  = i_next_instr_addr;
                    state_d = StReq;
                end
            end
            StReq: begin
                // A misaligned address never reaches the bus.
                if (misaligned) begin
                    state_d    = StErr;
                    err_code_d = ErrMisaligned;
                end else if (i_mem_rsp_valid) begin
                    // Memory latency is at least one cycle, so even a response
                    // coinciding with the accept cannot belong to this request.
                    state_d    = StErr;
                    err_code_d = ErrUnexpected;
                end else if (i_mem_req_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (i_mem_rsp_valid) begin
                    if (i_mem_rsp_err) begin
                        state_d    = StErr;
                        err_code_d = ErrBus;
                    end else begin
                        instr_d = i_mem_rsp_data;
                        state_d = StOut;
                    end
                end
            end
            StOut: begin
                if (i_mem_rsp_valid) begin
                    state_d    = StErr;
                    err_code_d = ErrUnexpected;
                end else if (handshake) begin
                    addr_d  = i_next_instr_addr;
                    count_d = count_q + 32'd1;
                    state_d = StReq;
                end
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Moore outputs per state, plus the stall release in the handshake cycle.
    always_comb begin
        o_stall         = 1'b1;
        o_mem_req_valid = 1'b0;
        o_instr_valid   = 1'b0;
        o_err           = 1'b0;
        unique case (state_q)
            StIdle: o_stall = 1'b0;
            StReq:  o_mem_req_valid = !misaligned;
            StWait: o_stall = 1'b1;
            StOut: begin
                o_instr_valid = 1'b1;
                o_stall       = !handshake;
            end
            StErr:  o_err = 1'b1;
            default: o_stall = 1'b1;
        endcase
        // The state register reads IDLE during reset, but the branch facility
        // must stay held until reset is released.
        if (i_rst) begin
            o_stall = 1'b1;
        end
    end

    assign o_mem_addr    = addr_q;
    assign o_instr_addr  = addr_q;
    assign o_instr       = instr_q;
    assign o_fetch_count = count_q;
    assign o_err_code    = err_code_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a directed vector table, hand-written error and reset
// sequences, then randomized traffic checked against a transaction-level model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] nxt_addr;
    logic        stall;
    logic        mreq_v;
    logic        mreq_rdy;
    logic [63:0] maddr;
    logic        mrsp_v;
    logic [31:0] mrsp_data;
    logic        mrsp_err;
    logic [31:0] instr;
    logic [63:0] instr_addr;
    logic        instr_v;
    logic        instr_rdy;
    logic [31:0] fcount;
    logic        err;
    logic [1:0]  err_code;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_ADDR(64'h0)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_next_instr_addr (nxt_addr),
        .o_stall           (stall),
        .o_mem_req_valid   (mreq_v),
        .i_mem_req_ready   (mreq_rdy),
        .o_mem_addr        (maddr),
        .i_mem_rsp_valid   (mrsp_v),
        .i_mem_rsp_data    (mrsp_data),
        .i_mem_rsp_err     (mrsp_err),
        .o_instr           (instr),
        .o_instr_addr      (instr_addr),
        .o_instr_valid     (instr_v),
        .i_instr_ready     (instr_rdy),
        .o_fetch_count     (fcount),
        .o_err             (err),
        .o_err_code        (err_code)
    );

    typedef struct {
        logic [63:0] nxt;
        logic        mrdy;
        logic        rspv;
        logic [31:0] data;
        logic        rerr;
        logic        irdy;
        logic        e_stall;
        logic        e_reqv;
        logic [63:0] e_maddr;
        logic        e_iv;
        logic [31:0] e_instr;
        logic [63:0] e_iaddr;
        logic [31:0] e_cnt;
        logic        e_err;
        logic [1:0]  e_code;
    } vec_t;

    // Reference model state
    logic        m_fresh, m_infl, m_have, m_dead;
    logic [1:0]  m_code;
    logic [63:0] m_addr;
    logic [31:0] m_instr, m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs at the current (negedge) time and settle.
    task automatic drive(input logic [63:0] n, input logic mr, input logic rv,
                         input logic [31:0] d, input logic re, input logic ir);
        nxt_addr  = n;
        mreq_rdy  = mr;
        mrsp_v    = rv;
        mrsp_data = d;
        mrsp_err  = re;
        instr_rdy = ir;
        #1;
    endtask

    task automatic adv;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        nxt_addr  = '0;
        mreq_rdy  = 1'b0;
        mrsp_v    = 1'b0;
        mrsp_data = '0;
        mrsp_err  = 1'b0;
        instr_rdy = 1'b0;
    endtask

    // Assert reset at the current time, check outputs before any clock edge,
    // release just after the next falling edge.
    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("rst_stall", {63'd0, stall}, 64'd1);
        chk("rst_reqv", {63'd0, mreq_v}, 64'd0);
        chk("rst_iv", {63'd0, instr_v}, 64'd0);
        chk("rst_instr", {32'd0, instr}, 64'd0);
        chk("rst_iaddr", instr_addr, 64'h0);
        chk("rst_cnt", {32'd0, fcount}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_code", {62'd0, err_code}, 64'd0);
        @(negedge clk);
        rst      = 1'b0;
        m_fresh  = 1'b1;
        m_infl   = 1'b0;
        m_have   = 1'b0;
        m_dead   = 1'b0;
        m_code   = 2'b00;
        m_addr   = 64'h0;
        m_instr  = '0;
        m_cnt    = '0;
    endtask

    // Compare current outputs with the model and advance the model one cycle.
    task automatic model_cycle;
        logic e_stall, e_reqv, e_iv;
        e_stall = 1'b1;
        e_reqv  = 1'b0;
        e_iv    = 1'b0;
        if (m_dead) begin
            e_stall = 1'b1;
        end else if (m_fresh) begin
            e_stall = 1'b0;
        end else if (m_have) begin
            e_iv    = 1'b1;
            e_stall = !(instr_rdy && !mrsp_v);
        end else if (!m_infl) begin
            e_reqv = (m_addr[1:0] == 2'b00);
        end
        chk("m_stall", {63'd0, stall}, {63'd0, e_stall});
        chk("m_reqv", {63'd0, mreq_v}, {63'd0, e_reqv});
        if (e_reqv) chk("m_maddr", maddr, m_addr);
        chk("m_iv", {63'd0, instr_v}, {63'd0, e_iv});
        chk("m_instr", {32'd0, instr}, {32'd0, m_instr});
        chk("m_iaddr", instr_addr, m_addr);
        chk("m_cnt", {32'd0, fcount}, {32'd0, m_cnt});
        chk("m_err", {63'd0, err}, {63'd0, m_dead});
        chk("m_code", {62'd0, err_code}, {62'd0, m_code});
        if (m_dead) begin
            // terminal
        end else if (m_fresh) begin
            if (mrsp_v) begin m_dead = 1'b1; m_code = 2'b11; end
            else begin m_addr = nxt_addr; m_fresh = 1'b0; end
        end else if (m_have) begin
            if (mrsp_v) begin m_dead = 1'b1; m_code = 2'b11; end
            else if (instr_rdy) begin
                m_addr = nxt_addr;
                m_cnt  = m_cnt + 1;
                m_have = 1'b0;
            end
        end else if (m_infl) begin
            if (mrsp_v) begin
                m_infl = 1'b0;
                if (mrsp_err) begin m_dead = 1'b1; m_code = 2'b10; end
                else begin m_instr = mrsp_data; m_have = 1'b1; end
            end
        end else begin
            if (m_addr[1:0] != 2'b00) begin m_dead = 1'b1; m_code = 2'b01; end
            else if (mrsp_v) begin m_dead = 1'b1; m_code = 2'b11; end
            else if (mreq_rdy) m_infl = 1'b1;
        end
    endtask

    initial begin
        vec_t tbl[14];
        logic [63:0] a;
        logic rv;

        // Sequential fetch, request/response backpressure, redirect, then a
        // response arriving while a request is still pending.
        //          nxt     mr rv data          re ir | st rq maddr  iv instr         iaddr   cnt err code
        tbl[0]  = '{64'h0,  0, 0, 32'h0,         0, 0,  0, 0, 64'h0,  0, 32'h0,         64'h0,   0, 0, 2'b00};
        tbl[1]  = '{64'h0,  1, 0, 32'h0,         0, 0,  1, 1, 64'h0,  0, 32'h0,         64'h0,   0, 0, 2'b00};
        tbl[2]  = '{64'h0,  0, 1, 32'h4800_0010, 0, 0,  1, 0, 64'h0,  0, 32'h0,         64'h0,   0, 0, 2'b00};
        tbl[3]  = '{64'h4,  0, 0, 32'h0,         0, 1,  0, 0, 64'h0,  1, 32'h4800_0010, 64'h0,   0, 0, 2'b00};
        tbl[4]  = '{64'h0,  0, 0, 32'h0,         0, 0,  1, 1, 64'h4,  0, 32'h4800_0010, 64'h4,   1, 0, 2'b00};
        tbl[5]  = '{64'h0,  0, 0, 32'h0,         0, 0,  1, 1, 64'h4,  0, 32'h4800_0010, 64'h4,   1, 0, 2'b00};
        tbl[6]  = '{64'h0,  0, 0, 32'h0,         0, 0,  1, 1, 64'h4,  0, 32'h4800_0010, 64'h4,   1, 0, 2'b00};
        tbl[7]  = '{64'h0,  1, 0, 32'h0,         0, 0,  1, 1, 64'h4,  0, 32'h4800_0010, 64'h4,   1, 0, 2'b00};
        tbl[8]  = '{64'h0,  0, 1, 32'h6000_0000, 0, 0,  1, 0, 64'h0,  0, 32'h4800_0010, 64'h4,   1, 0, 2'b00};
        tbl[9]  = '{64'h100,0, 0, 32'h0,         0, 0,  1, 0, 64'h0,  1, 32'h6000_0000, 64'h4,   1, 0, 2'b00};
        tbl[10] = '{64'h100,0, 0, 32'h0,         0, 0,  1, 0, 64'h0,  1, 32'h6000_0000, 64'h4,   1, 0, 2'b00};
        tbl[11] = '{64'h100,0, 0, 32'h0,         0, 1,  0, 0, 64'h0,  1, 32'h6000_0000, 64'h4,   1, 0, 2'b00};
        tbl[12] = '{64'h0,  0, 1, 32'h0,         0, 0,  1, 1, 64'h100,0, 32'h6000_0000, 64'h100, 2, 0, 2'b00};
        tbl[13] = '{64'h0,  0, 0, 32'h0,         0, 0,  1, 0, 64'h0,  0, 32'h6000_0000, 64'h100, 2, 1, 2'b11};

        idle_inputs();
        #2;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].nxt, tbl[i].mrdy, tbl[i].rspv, tbl[i].data, tbl[i].rerr, tbl[i].irdy);
            chk($sformatf("v%0d_stall", i), {63'd0, stall}, {63'd0, tbl[i].e_stall});
            chk($sformatf("v%0d_reqv", i), {63'd0, mreq_v}, {63'd0, tbl[i].e_reqv});
            if (tbl[i].e_reqv) chk($sformatf("v%0d_maddr", i), maddr, tbl[i].e_maddr);
            chk($sformatf("v%0d_iv", i), {63'd0, instr_v}, {63'd0, tbl[i].e_iv});
            chk($sformatf("v%0d_instr", i), {32'd0, instr}, {32'd0, tbl[i].e_instr});
            chk($sformatf("v%0d_iaddr", i), instr_addr, tbl[i].e_iaddr);
            chk($sformatf("v%0d_cnt", i), {32'd0, fcount}, {32'd0, tbl[i].e_cnt});
            chk($sformatf("v%0d_err", i), {63'd0, err}, {63'd0, tbl[i].e_err});
            chk($sformatf("v%0d_code", i), {62'd0, err_code}, {62'd0, tbl[i].e_code});
            adv();
        end

        // Misaligned address: no request, error code 01.
        do_reset();
        drive(64'h102, 0, 0, 0, 0, 0);
        adv();
        drive(64'h0, 1, 0, 0, 0, 0);
        chk("mis_noreq", {63'd0, mreq_v}, 64'd0);
        chk("mis_iaddr", instr_addr, 64'h102);
        adv();
        drive(64'h0, 1, 0, 0, 0, 0);
        chk("mis_noreq2", {63'd0, mreq_v}, 64'd0);
        chk("mis_err", {63'd0, err}, 64'd1);
        chk("mis_code", {62'd0, err_code}, 64'd1);

        // Bus error response: code 10.
        do_reset();
        drive(64'h8, 0, 0, 0, 0, 0);
        adv();
        drive(64'h0, 1, 0, 0, 0, 0);
        adv();
        drive(64'h0, 0, 1, 32'hDEAD_BEEF, 1, 0);
        adv();
        drive(64'h0, 0, 0, 0, 0, 1);
        chk("bus_err", {63'd0, err}, 64'd1);
        chk("bus_code", {62'd0, err_code}, 64'd2);
        chk("bus_iv", {63'd0, instr_v}, 64'd0);
        chk("bus_stall", {63'd0, stall}, 64'd1);

        // Async reset in WAIT.
        do_reset();
        drive(64'h20, 0, 0, 0, 0, 0);
        adv();
        drive(64'h0, 1, 0, 0, 0, 0);
        adv();
        drive(64'h0, 0, 0, 0, 0, 0);
        chk("wait_stall", {63'd0, stall}, 64'd1);
        chk("wait_iaddr", instr_addr, 64'h20);
        #1;
        do_reset();

        // Counter wrap: preload the counter, complete one fetch.
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        drive(64'h40, 0, 0, 0, 0, 0);
        chk("wrap_pre", {32'd0, fcount}, 64'hFFFF_FFFF);
        adv();
        drive(64'h0, 1, 0, 0, 0, 0);
        adv();
        drive(64'h0, 0, 1, 32'h1234_5678, 0, 0);
        adv();
        drive(64'h44, 0, 0, 0, 0, 1);
        chk("wrap_hs_stall", {63'd0, stall}, 64'd0);
        adv();
        drive(64'h0, 1, 0, 0, 0, 0);
        chk("wrap_cnt", {32'd0, fcount}, 64'd0);
        chk("wrap_maddr", maddr, 64'h44);
        adv();
        drive(64'h0, 0, 1, 32'h9ABC_DEF0, 0, 0);
        adv();
        drive(64'h0, 0, 0, 0, 0, 0);
        chk("out_iv", {63'd0, instr_v}, 64'd1);
        chk("out_instr", {32'd0, instr}, 64'h9ABC_DEF0);
        // Async reset in OUT.
        #2;
        do_reset();

        // Randomized traffic against the model.
        for (int ep = 0; ep < 25; ep++) begin
            do_reset();
            for (int c = 0; c < 80; c++) begin
                a = {$urandom, $urandom};
                if ($urandom_range(24, 0) != 0) a[1:0] = 2'b00;
                if (m_infl) rv = ($urandom_range(2, 0) == 0);
                else        rv = ($urandom_range(59, 0) == 0);
                drive(a, 1'($urandom_range(1, 0)), rv, $urandom,
                      ($urandom_range(19, 0) == 0), 1'($urandom_range(1, 0)));
                model_cycle();
                adv();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
